ctrl_decode_ex: RTL and testbench
=================================

Name: ctrl_decode_ex

Overview:
- Registered instruction-decode/control stage between ID and EX of the pipelined MIPS core.
- Replaces the combinational-style R-type decoder with a clocked one that adds a valid/ready handshake, stall/flush, I-type decode (addi/addiu/ori/lui), defined GPIO pulses, and a HI/LO multiply-latency interlock.
- All control outputs are EX-stage registers that feed the ALU, the HI/LO block and the writeback select.

Parameters:
- ALU_OP_W, 4: alu_op width. Codes below are zero-extended; must be >= 4.
- SHAMT_W, 5: shift-amount field width.
- MULT_LAT, 4: cycles a mult/multu occupies HI/LO after entering EX. 0 disables the interlock.
- LUI_SHIFT, 16: shift amount forced for lui.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  instruction_ID holds a valid instruction
- instruction_ID  in  32  instruction word from ID
- stall_in  in  1  downstream hold; EX registers keep their value
- flush  in  1  kill the instruction entering EX
- id_ready  out  1  ID may advance this cycle
- ex_valid  out  1  EX registers hold a real instruction
- alu_op  out  ALU_OP_W  ALU operation
- shamt_EX  out  SHAMT_W  shift amount
- regsel_EX  out  2  writeback source: 0 ALU, 1 HI, 2 LO, 3 GPIO input
- enhilo_EX  out  1  HI/LO write enable
- regwrite_EX  out  1  register-file write enable
- rdrt_EX  out  1  destination select: 0 rd, 1 rt
- alu_src_EX  out  2  operand B: 0 rt, 1 sign-extended imm, 2 zero-extended imm
- gpio_out_EX  out  1  one-instruction GPIO write pulse
- gpio_in_EX  out  1  one-instruction GPIO read pulse
- illegal_EX  out  1  undecodable instruction in EX

Behaviour:
- Reset (async, rst=1): every output and the busy counter are cleared to 0. Bubble = all outputs 0.
- Latency: decode result appears on outputs 1 cycle after the accepting edge.
- Accept condition: id_valid & id_ready.
- id_ready = ~stall_in & ~hilo_hazard.
- hilo_hazard = (busy_cnt != 0) & decoded instruction is mfhi, mflo, mult or multu.
- Per edge, in priority order:
  - flush: load bubble. This overrides stall_in.
  - else stall_in: hold all EX registers.
  - else accepted: load the decoded fields.
  - else (not valid, or hazard): load bubble.
- Busy counter:
  - Loads MULT_LAT on the edge that loads a mult/multu into EX.
  - Otherwise decrements while nonzero; it also decrements during stall_in.
  - flush does not clear the counter.
- R-type decode (opcode 000000), giving funct -> alu_op with other fields:
  - Instruction word all zero: NOP = bubble fields, but ex_valid=1.
  - 100000/100001 add/addu -> 0100.
  - 100010/100011 sub/subu -> 0101.
  - 011000 mult -> 0110; 011001 multu -> 0111. Both set enhilo=1, regwrite=0.
  - 100100 and -> 0000; 100101 or -> 0001; 100111 nor -> 0010; 100110 xor -> 0011.
  - 000000 sll -> 1000, shamt_EX = instr[10:6].
  - 000010 srl:
    - shamt!=0: 1001, shamt_EX = instr[10:6].
    - shamt==0: gpio_out=1, regwrite=0.
  - 000011 sra:
    - shamt!=0: 1010, shamt_EX = instr[10:6].
    - shamt==0: gpio_in=1, regsel=3, regwrite=1.
  - 010000 mfhi: regsel=1. 010010 mflo: regsel=2.
  - 101010 slt -> 1100; 101011 sltu -> 1101.
  - All the above default to regwrite=1, rdrt=0, alu_src=0 unless stated otherwise.
- I-type decode (all set rdrt=1, regwrite=1):
  - 001000/001001 addi/addiu: 0100, alu_src=1.
  - 001101 ori: 0001, alu_src=2.
  - 001111 lui: 1000, alu_src=1, shamt_EX=LUI_SHIFT.
- Unused fields are driven to 0, never X.
- Any other opcode/funct: illegal (see the optional feature).
- GPIO pulses: last exactly one cycle unless held by stall_in. They are cleared by flush or by any new load.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction loads as a bubble with ex_valid=1 and illegal_EX=1.
  - A sticky internal flag is set and holds illegal_EX high until rst.
  - While the flag is set, id_ready=0.
- Undefined:
  - Illegal instructions load as NOP (ex_valid=1, all controls 0).
  - illegal_EX is tied 0.

Test Plan:
- Reset mid-stream: rst pulsed while ex_valid=1 and alu_op=0101 -> all outputs 0 immediately, asynchronously, before the next edge.
- add $3,$1,$2 (0x00221820), id_valid=1 -> next cycle: alu_op=0100, regwrite=1, rdrt=0, regsel=0, ex_valid=1.
- MULT_LAT=4: mult (0x00220018) then mflo (0x00001812) -> id_ready=0 for 4 cycles, EX carries bubbles; then mflo loads with regsel=2, regwrite=1.
- srl with shamt 0 (0x00011002) -> gpio_out_EX=1 for 1 cycle, regwrite=0. srl with shamt 4 (0x00011102) -> alu_op=1001, shamt_EX=4.
- lui 0x3C011234 -> alu_op=1000, shamt_EX=16, alu_src=1, rdrt=1. Same instruction with stall_in=1 for 3 cycles -> outputs held, id_ready=0. stall_in and flush together -> bubble.
- Opcode 0x3F with CTRL_ILLEGAL_TRAP_EN defined -> illegal_EX=1 and id_ready=0 until rst. Without the macro -> NOP with ex_valid=1 and illegal_EX=0.

Source files
------------

// File: rtl/ctrl_decode_ex.sv
// ctrl_decode_ex: registered ID->EX decode/control stage with valid/ready handshake,
// stall/flush, R/I-type decode, GPIO pulses and a HI/LO multiply-latency interlock.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal trap that blocks ID).
module ctrl_decode_ex #(
    parameter int ALU_OP_W  = 4,
    parameter int SHAMT_W   = 5,
    parameter int MULT_LAT  = 4,
    parameter int LUI_SHIFT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [31:0]         instruction_ID,
    input  logic                stall_in,
    input  logic                flush,
    output logic                id_ready,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [SHAMT_W-1:0]  shamt_EX,
    output logic [1:0]          regsel_EX,
    output logic                enhilo_EX,
    output logic                regwrite_EX,
    output logic                rdrt_EX,
    output logic [1:0]          alu_src_EX,
    output logic                gpio_out_EX,
    output logic                gpio_in_EX,
    output logic                illegal_EX
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int CNT_W = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;

    logic [5:0]         opcode, funct;
    logic [4:0]         sa;
    logic [3:0]         d_alu;
    logic [SHAMT_W-1:0] d_shamt;
    logic [1:0]         d_regsel, d_alusrc;
    logic               d_enhilo, d_regwrite, d_rdrt, d_gpo, d_gpi, d_illegal, d_hilo;
    logic [CNT_W-1:0]   busy;
    logic               trap, hilo_hazard, take;

    assign opcode = instruction_ID[31:26];
    assign funct  = instruction_ID[5:0];
    assign sa     = instruction_ID[10:6];

    // Combinational decode of the instruction word sitting in ID; unused fields stay 0
    always_comb begin
        d_alu      = 4'b0000;
        d_shamt    = '0;
        d_regsel   = 2'd0;
        d_alusrc   = 2'd0;
        d_enhilo   = 1'b0;
        d_regwrite = 1'b0;
        d_rdrt     = 1'b0;
        d_gpo      = 1'b0;
        d_gpi      = 1'b0;
        d_illegal  = 1'b0;
        d_hilo     = 1'b0;
        if (instruction_ID == 32'd0) begin
            d_alu = 4'b0000;
        end else if (opcode == 6'b000000) begin
            d_regwrite = 1'b1;
            case (funct)
                6'b100000, 6'b100001: d_alu = 4'b0100;
                6'b100010, 6'b100011: d_alu = 4'b0101;
                6'b011000, 6'b011001: begin
                    d_alu      = {3'b011, funct[0]};
                    d_enhilo   = 1'b1;
                    d_regwrite = 1'b0;
                    d_hilo     = 1'b1;
                end
                6'b100100: d_alu = 4'b0000;
                6'b100101: d_alu = 4'b0001;
                6'b100111: d_alu = 4'b0010;
                6'b100110: d_alu = 4'b0011;
                6'b000000: begin
                    d_alu   = 4'b1000;
                    d_shamt = SHAMT_W'(sa);
                end
                6'b000010: begin
                    d_alu      = (sa != 5'd0) ? 4'b1001 : 4'b0000;
                    d_shamt    = (sa != 5'd0) ? SHAMT_W'(sa) : '0;
                    d_gpo      = (sa == 5'd0);
                    d_regwrite = (sa != 5'd0);
                end
                6'b000011: begin
                    d_alu    = (sa != 5'd0) ? 4'b1010 : 4'b0000;
                    d_shamt  = (sa != 5'd0) ? SHAMT_W'(sa) : '0;
                    d_gpi    = (sa == 5'd0);
                    d_regsel = (sa == 5'd0) ? 2'd3 : 2'd0;
                end
                6'b010000: begin
                    d_regsel = 2'd1;
                    d_hilo   = 1'b1;
                end
                6'b010010: begin
                    d_regsel = 2'd2;
                    d_hilo   = 1'b1;
                end
                6'b101010: d_alu = 4'b1100;
                6'b101011: d_alu = 4'b1101;
                default: begin
                    d_illegal  = 1'b1;
                    d_regwrite = 1'b0;
                end
            endcase
        end else begin
            d_rdrt     = 1'b1;
            d_regwrite = 1'b1;
            case (opcode)
                6'b001000, 6'b001001: begin
                    d_alu    = 4'b0100;
                    d_alusrc = 2'd1;
                end
                6'b001101: begin
                    d_alu    = 4'b0001;
                    d_alusrc = 2'd2;
                end
                6'b001111: begin
                    d_alu    = 4'b1000;
                    d_alusrc = 2'd1;
                    d_shamt  = SHAMT_W'(LUI_SHIFT);
                end
                default: begin
                    d_illegal  = 1'b1;
                    d_rdrt     = 1'b0;
                    d_regwrite = 1'b0;
                end
            endcase
        end
    end

    // HI/LO users must wait until an in-flight multiply has drained
    assign hilo_hazard = (busy != '0) & d_hilo;
    assign id_ready    = ~stall_in & ~hilo_hazard & ~trap;
    assign take        = id_valid & id_ready & ~flush;
    assign illegal_EX  = trap;

    // Multiply occupancy counter: reload on a mult entering EX, otherwise drain (also while stalled)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else if (take && d_enhilo)
            busy <= CNT_W'(MULT_LAT);
        else if (busy != '0)
            busy <= busy - CNT_W'(1);
    end

    // Sticky illegal flag; constant 0 when the trap feature is compiled out
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trap <= 1'b0;
        else if (TRAP_EN && take && d_illegal)
            trap <= 1'b1;
    end

    // EX registers: flush forces a bubble, stall holds, otherwise load decode or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            alu_op      <= '0;
            shamt_EX    <= '0;
            regsel_EX   <= 2'd0;
            enhilo_EX   <= 1'b0;
            regwrite_EX <= 1'b0;
            rdrt_EX     <= 1'b0;
            alu_src_EX  <= 2'd0;
            gpio_out_EX <= 1'b0;
            gpio_in_EX  <= 1'b0;
        end else if (flush || !stall_in) begin
            ex_valid    <= take;
            alu_op      <= take ? ALU_OP_W'(d_alu) : '0;
            shamt_EX    <= take ? d_shamt : '0;
            regsel_EX   <= take ? d_regsel : 2'd0;
            enhilo_EX   <= take & d_enhilo;
            regwrite_EX <= take & d_regwrite;
            rdrt_EX     <= take & d_rdrt;
            alu_src_EX  <= take ? d_alusrc : 2'd0;
            gpio_out_EX <= take & d_gpo;
            gpio_in_EX  <= take & d_gpi;
        end
    end
endmodule

// File: tb/tb_ctrl_decode_ex.sv
// tb_ctrl_decode_ex: directed + randomized checks of ctrl_decode_ex against a behavioural model.
module tb_ctrl_decode_ex;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [3:0] alu;
        logic [4:0] sh;
        logic [1:0] rs;
        logic       hl;
        logic       rw;
        logic       rd;
        logic [1:0] src;
        logic       go;
        logic       gi;
        logic       il;
    } ex_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        id_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
    logic [31:0] instruction_ID = 32'd0;
    logic        id_ready, ex_valid, enhilo_EX, regwrite_EX, rdrt_EX;
    logic        gpio_out_EX, gpio_in_EX, illegal_EX;
    logic [3:0]  alu_op;
    logic [4:0]  shamt_EX;
    logic [1:0]  regsel_EX, alu_src_EX;
    logic [19:0] obs;

    int   checks = 0, failures = 0;
    int   m_busy = 0;
    bit   m_trap = 1'b0;
    ex_t  m_ex = '0;
    logic [3:0] r_alu [int];
    logic [5:0] functs [17] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd24, 6'd25, 6'd36, 6'd37,
                               6'd39, 6'd38, 6'd0, 6'd2, 6'd3, 6'd16, 6'd18, 6'd42, 6'd43};

    ctrl_decode_ex dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instruction_ID(instruction_ID),
        .stall_in(stall_in), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
        .alu_op(alu_op), .shamt_EX(shamt_EX), .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX),
        .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX), .alu_src_EX(alu_src_EX),
        .gpio_out_EX(gpio_out_EX), .gpio_in_EX(gpio_in_EX), .illegal_EX(illegal_EX)
    );

    assign obs = {ex_valid, alu_op, shamt_EX, regsel_EX, enhilo_EX, regwrite_EX, rdrt_EX,
                  alu_src_EX, gpio_out_EX, gpio_in_EX, illegal_EX};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction tables: expected EX contents plus hazard/legality flags
    function automatic ex_t model_dec(input logic [31:0] w, output bit legal,
                                      output bit hilo_use, output bit is_mult);
        ex_t e = '0;
        int  f = int'(w[5:0]);
        int  op = int'(w[31:26]);
        legal = 1'b1;
        hilo_use = 1'b0;
        is_mult = 1'b0;
        e.v = 1'b1;
        if (w == 32'd0) return e;
        if (op == 0) begin
            if (!r_alu.exists(f)) begin
                legal = 1'b0;
                return e;
            end
            e.alu = r_alu[f];
            e.rw = 1'b1;
            if (f == 24 || f == 25) begin
                e.hl = 1'b1;
                e.rw = 1'b0;
                is_mult = 1'b1;
                hilo_use = 1'b1;
            end
            if (f == 16 || f == 18) begin
                e.rs = (f == 16) ? 2'd1 : 2'd2;
                hilo_use = 1'b1;
            end
            if (f == 0 || f == 2 || f == 3) e.sh = w[10:6];
            if ((f == 2 || f == 3) && w[10:6] == 5'd0) begin
                e.alu = 4'd0;
                if (f == 2) begin
                    e.go = 1'b1;
                    e.rw = 1'b0;
                end else begin
                    e.gi = 1'b1;
                    e.rs = 2'd3;
                end
            end
        end else begin
            e.rd = 1'b1;
            e.rw = 1'b1;
            if (op == 8 || op == 9) begin
                e.alu = 4'd4;
                e.src = 2'd1;
            end else if (op == 13) begin
                e.alu = 4'd1;
                e.src = 2'd2;
            end else if (op == 15) begin
                e.alu = 4'd8;
                e.src = 2'd1;
                e.sh = 5'd16;
            end else begin
                legal = 1'b0;
                e.rd = 1'b0;
                e.rw = 1'b0;
            end
        end
        return e;
    endfunction

    // One clock: drive at negedge, check id_ready, advance the model at posedge, check EX at next negedge
    task automatic cycle(input string tag, input logic v, input logic [31:0] w,
                         input logic st, input logic fl);
        bit  legal, hu, mu, ready, take;
        ex_t d;
        id_valid = v;
        instruction_ID = w;
        stall_in = st;
        flush = fl;
        d = model_dec(w, legal, hu, mu);
        ready = !st && !(m_busy > 0 && hu) && !m_trap;
        #1;
        check({tag, "_ready"}, 32'(id_ready), 32'(ready));
        @(posedge clk);
        take = v && ready && !fl;
        if (take && mu) m_busy = 4;
        else if (m_busy > 0) m_busy--;
        if (fl) m_ex = '0;
        else if (!st) m_ex = take ? d : '0;
        if (TRAP && take && !legal) m_trap = 1'b1;
        m_ex.il = m_trap;
        @(negedge clk);
        check({tag, "_ex"}, 32'(obs), 32'(m_ex));
    endtask

    // Raise rst mid-cycle and require outputs to clear before the next clock edge
    task automatic async_reset();
        id_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'(obs), 32'd0);
        m_busy = 0;
        m_trap = 1'b0;
        m_ex = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [5:0]  f = functs[$urandom_range(0, 16)];
        case ($urandom_range(0, 5))
            0: rand_instr = w;
            1: rand_instr = {6'd0, w[25:6], f};
            2: rand_instr = {($urandom_range(0, 1) == 1) ? 6'd13 : 6'd15, w[25:0]};
            3: rand_instr = {6'd0, w[25:11], ($urandom_range(0, 1) == 1) ? 5'd0 : w[10:6],
                             ($urandom_range(0, 1) == 1) ? 6'd2 : 6'd3};
            4: rand_instr = {6'd0, w[25:6], ($urandom_range(0, 1) == 1) ? 6'd24 : 6'd18};
            default: rand_instr = ($urandom_range(0, 1) == 1) ? 32'd0 : {6'd8, w[25:0]};
        endcase
    endfunction

    initial begin
        r_alu[32] = 4'd4;  r_alu[33] = 4'd4;  r_alu[34] = 4'd5;  r_alu[35] = 4'd5;
        r_alu[24] = 4'd6;  r_alu[25] = 4'd7;  r_alu[36] = 4'd0;  r_alu[37] = 4'd1;
        r_alu[39] = 4'd2;  r_alu[38] = 4'd3;  r_alu[0]  = 4'd8;  r_alu[2]  = 4'd9;
        r_alu[3]  = 4'd10; r_alu[16] = 4'd0;  r_alu[18] = 4'd0;  r_alu[42] = 4'd12;
        r_alu[43] = 4'd13;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", 32'(obs), 32'd0);
        cycle("add", 1'b1, 32'h00221820, 1'b0, 1'b0);
        cycle("mult", 1'b1, 32'h00220018, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("mflo", 1'b1, 32'h00001812, 1'b0, 1'b0);
        cycle("srl0", 1'b1, 32'h00011002, 1'b0, 1'b0);
        cycle("srl_gap", 1'b0, 32'h00011002, 1'b0, 1'b0);
        cycle("srl4", 1'b1, 32'h00011102, 1'b0, 1'b0);
        cycle("sra0", 1'b1, 32'h00011003, 1'b0, 1'b0);
        cycle("lui", 1'b1, 32'h3C011234, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("lui_stall", 1'b1, 32'h3C011234, 1'b1, 1'b0);
        cycle("stall_flush", 1'b1, 32'h3C011234, 1'b1, 1'b1);
        cycle("ori", 1'b1, 32'h34221234, 1'b0, 1'b0);
        cycle("sub", 1'b1, 32'h00221822, 1'b0, 1'b0);
        async_reset();
        check("post_rst_state", 32'(obs), 32'd0);
        cycle("illegal", 1'b1, 32'hFC000000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("after_illegal", 1'b1, 32'h00221820, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) async_reset();
            cycle("rand", ($urandom_range(0, 3) != 0), rand_instr(),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
